// File: rtl/morty_imm_ctrl.sv
// morty_imm_ctrl
//   Two-entry instruction buffer between fetch and execute. Each instruction
//   is decoded at enqueue time into an immediate-type select for the
//   immediate extender plus an illegal-opcode flag, and the result is stored
//   with the entry. Dequeuing an illegal instruction halts the block until
//   flush.
//
// Ports
//   clk, rst_n      clock; asynchronous active-low reset
//   flush           drop all buffered entries, return to RUN
//   in_valid/ready  fetch handshake (in_ready never depends on out_ready)
//   in_inst, in_pc  instruction word and its PC
//   out_valid/ready execute handshake for the head entry
//   out_inst/pc     head entry (zero when out_valid=0)
//   type_imm        0 U, 1 I, 2 B, 3 J, 4 S, 5 CSR, 6 shamt, 7 none
//   out_illegal     head entry has an unsupported opcode
//   ret_cnt         completed output handshakes, wraps
module morty_imm_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [31:0]      in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_inst,
   output logic [31:0]      out_pc,
   output logic [2:0]       type_imm,
   output logic             out_illegal,
   output logic [CNT_W-1:0] ret_cnt
);

   typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

   localparam logic [CNT_W-1:0] RET_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t             r_state;
   logic [31:0]        r_inst [2];
   logic [31:0]        r_pc   [2];
   logic [2:0]         r_type [2];
   logic               r_ill  [2];
   logic               r_wptr;
   logic               r_rptr;
   logic [1:0]         r_cnt;
   logic               r_live;     // low during reset, high from the first edge after it
   logic [CNT_W-1:0]   r_ret_cnt;

   logic               w_enq;
   logic               w_deq;
   logic [3:0]         w_dec;      // {illegal, type_imm}

   // Opcode decode; returns {illegal, type_imm}.
   function automatic logic [3:0] decode(input logic [31:0] inst);
      logic [3:0] d;
      d = {1'b1, 3'd7};
      case (inst[6:0])
         7'b0110111, 7'b0010111: d = {1'b0, 3'd0};
         7'b1100111, 7'b0000011: d = {1'b0, 3'd1};
         7'b0010011: d = (inst[13:12] == 2'b01) ? {1'b0, 3'd6} : {1'b0, 3'd1};
         7'b1100011: d = {1'b0, 3'd2};
         7'b1101111: d = {1'b0, 3'd3};
         7'b0100011: d = {1'b0, 3'd4};
         7'b1110011: d = inst[14] ? {1'b0, 3'd5} : {1'b0, 3'd7};
         7'b0110011, 7'b0001111: d = {1'b0, 3'd7};
         default: d = {1'b1, 3'd7};
      endcase
      return d;
   endfunction

   assign w_dec     = decode(in_inst);
   assign in_ready  = r_live & (r_state == S_RUN) & ~r_cnt[1] & ~flush;
   assign out_valid = (r_state == S_RUN) & (r_cnt != 2'd0);
   assign w_enq     = in_valid & in_ready;
   // flush overrides a dequeue in the same cycle, including its ret_cnt bump
   assign w_deq     = out_valid & out_ready & ~flush;

   assign out_inst    = out_valid ? r_inst[r_rptr] : 32'd0;
   assign out_pc      = out_valid ? r_pc[r_rptr]   : 32'd0;
   assign type_imm    = out_valid ? r_type[r_rptr] : 3'd0;
   assign out_illegal = out_valid & r_ill[r_rptr];
   assign ret_cnt     = r_ret_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_RUN;
         r_wptr    <= 1'b0;
         r_rptr    <= 1'b0;
         r_cnt     <= 2'd0;
         r_live    <= 1'b0;
         r_ret_cnt <= '0;
         for (int i = 0; i < 2; i++) begin
            r_inst[i] <= 32'd0;
            r_pc[i]   <= 32'd0;
            r_type[i] <= 3'd0;
            r_ill[i]  <= 1'b0;
         end
      end else begin
         r_live <= 1'b1;
         if (flush) begin
            r_state <= S_RUN;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_cnt   <= 2'd0;
         end else begin
            if (w_enq) begin
               r_inst[r_wptr] <= in_inst;
               r_pc[r_wptr]   <= in_pc;
               r_type[r_wptr] <= w_dec[2:0];
               r_ill[r_wptr]  <= w_dec[3];
               r_wptr         <= ~r_wptr;
            end
            if (w_deq) begin
               r_rptr    <= ~r_rptr;
               r_ret_cnt <= r_ret_cnt + RET_ONE;
               if (r_ill[r_rptr]) r_state <= S_HALT;
            end
            case ({w_enq, w_deq})
               2'b10:   r_cnt <= r_cnt + 2'd1;
               2'b01:   r_cnt <= r_cnt - 2'd1;
               default: r_cnt <= r_cnt;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_morty_imm_ctrl.sv
// Scoreboard bench for morty_imm_ctrl. The driver issues directed and random
// stimulus; the negedge reference process keeps a queue of expected entries,
// compares the DUT each cycle, and pops on every output handshake.
module tb_morty_imm_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic [2:0]  type_imm;
   logic        out_illegal;
   logic [15:0] ret_cnt;

   morty_imm_ctrl #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
      .type_imm(type_imm), .out_illegal(out_illegal), .ret_cnt(ret_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [2:0]  ty;
      logic        ill;
   } ent_t;

   ent_t        q[$];
   bit          m_halt = 0;
   bit          m_live = 0;
   logic [15:0] m_ret  = 0;
   int          n_vec  = 0;
   int          n_err  = 0;
   logic [31:0] pc_ctr = 32'h1000;

   logic [6:0] legal_ops [11] = '{7'h37, 7'h17, 7'h67, 7'h03, 7'h13, 7'h63,
                                  7'h6F, 7'h23, 7'h73, 7'h33, 7'h0F};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Reference decode: immediate type from the RV32I instruction format.
   function automatic ent_t ref_entry(input logic [31:0] inst, input logic [31:0] pc);
      ent_t e;
      logic [6:0] op = inst[6:0];
      logic [2:0] f3 = inst[14:12];
      e.inst = inst; e.pc = pc; e.ill = 1'b0;
      if (op == 7'h37 || op == 7'h17)      e.ty = 3'd0;  // LUI/AUIPC
      else if (op == 7'h67 || op == 7'h03) e.ty = 3'd1;  // JALR/loads
      else if (op == 7'h13)                e.ty = (f3 == 3'd1 || f3 == 3'd5) ? 3'd6 : 3'd1;
      else if (op == 7'h63)                e.ty = 3'd2;
      else if (op == 7'h6F)                e.ty = 3'd3;
      else if (op == 7'h23)                e.ty = 3'd4;
      else if (op == 7'h73)                e.ty = (f3 >= 3'd4) ? 3'd5 : 3'd7;
      else if (op == 7'h33 || op == 7'h0F) e.ty = 3'd7;
      else begin e.ty = 3'd7; e.ill = 1'b1; end
      return e;
   endfunction

   function automatic logic [31:0] rnd_inst(input bit legal);
      logic [31:0] w;
      w = $urandom;
      if (legal) w[6:0] = legal_ops[$urandom_range(10)];
      else       w[6:0] = ($urandom_range(1) == 1) ? 7'h00 : 7'h7F;
      return w;
   endfunction

   // Reference model and monitor.
   always @(negedge clk) begin
      bit   e_rdy, e_vld;
      ent_t h;
      if (!rst_n) begin
         q.delete(); m_halt = 0; m_live = 0; m_ret = 0;
         chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
         chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
         chk("rst_out_inst", out_inst, 32'd0);
         chk("rst_out_pc", out_pc, 32'd0);
         chk("rst_type_imm", {29'd0, type_imm}, 32'd0);
         chk("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
         chk("rst_ret_cnt", {16'd0, ret_cnt}, 32'd0);
      end else begin
         e_rdy = m_live && !m_halt && q.size() < 2 && !flush;
         e_vld = !m_halt && q.size() > 0;
         chk("in_ready", {31'd0, in_ready}, {31'd0, e_rdy});
         chk("out_valid", {31'd0, out_valid}, {31'd0, e_vld});
         chk("ret_cnt", {16'd0, ret_cnt}, {16'd0, m_ret});
         if (e_vld) begin
            chk("out_inst", out_inst, q[0].inst);
            chk("out_pc", out_pc, q[0].pc);
            chk("type_imm", {29'd0, type_imm}, {29'd0, q[0].ty});
            chk("out_illegal", {31'd0, out_illegal}, {31'd0, q[0].ill});
         end else begin
            chk("idle_out_inst", out_inst, 32'd0);
            chk("idle_type_imm", {29'd0, type_imm}, 32'd0);
         end
         // advance the model to the state after the coming rising edge
         if (flush) begin
            q.delete(); m_halt = 0;
         end else begin
            if (e_vld && out_ready) begin
               h = q.pop_front();
               m_ret++;
               if (h.ill) m_halt = 1;
            end
            if (in_valid && e_rdy) q.push_back(ref_entry(in_inst, in_pc));
         end
         m_live = 1;
      end
   end

   task automatic cyc(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
      in_valid = v; in_inst = ins; in_pc = pc_ctr; out_ready = rdy; flush = fl;
      pc_ctr += 4;
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 0; flush = 0; in_valid = 0; in_inst = 0; in_pc = 0; out_ready = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;

      // lui, addi, slli streamed with out_ready=1
      cyc(1, 32'h000012B7, 1, 0);
      cyc(1, 32'h00500093, 1, 0);
      cyc(1, 32'h00309093, 1, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);

      // beq, csrrwi held, third offer refused, then drained
      cyc(1, 32'h00000063, 0, 0);
      cyc(1, 32'h3401D073, 0, 0);
      cyc(1, 32'h00000013, 0, 0);
      cyc(0, 0, 0, 0);
      repeat (3) cyc(0, 0, 1, 0);

      // illegal instruction halts until flush
      cyc(1, 32'h00000000, 1, 0);
      repeat (3) cyc(0, 0, 1, 0);
      cyc(1, 32'h00500093, 1, 0);
      cyc(0, 0, 1, 1);
      cyc(1, 32'h00500093, 1, 0);
      cyc(0, 0, 1, 0);

      // flush with a full FIFO and a simultaneous offer
      cyc(1, 32'h00000063, 0, 0);
      cyc(1, 32'h00500093, 0, 0);
      cyc(1, 32'h000012B7, 0, 1);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 0);

      // random traffic with occasional illegal opcodes and flushes
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(9) < 7, rnd_inst($urandom_range(19) != 0),
             $urandom_range(9) < 7, $urandom_range(29) == 0);

      // full-rate stream carries ret_cnt through 0xFFFF -> 0x0000
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 65540; i++) cyc(1, rnd_inst(1), 1, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);

      // asynchronous reset with two entries buffered
      cyc(1, 32'h00500093, 0, 0);
      cyc(1, 32'h00309093, 0, 0);
      #2 rst_n = 0;
      #1;
      chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("async_rst_out_inst", out_inst, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      cyc(0, 0, 0, 0);
      cyc(1, 32'h00500093, 1, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/morty_imm_ctrl.md
MORTY_IMM_CTRL -- requirements
Module: morty_imm_ctrl

Interface
REQ-001 Parameter: CNT_W, default 16, width of the retired-instruction counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 flush  input  1  discard all buffered instructions and leave HALT.
REQ-005 in_valid  input  1  fetch offers an instruction.
REQ-006 in_ready  output  1  block accepts the instruction this cycle.
REQ-007 in_inst  input  32  raw RV32I instruction word.
REQ-008 in_pc  input  32  PC of in_inst.
REQ-009 out_valid  output  1  head entry is valid.
REQ-010 out_ready  input  1  execute stage consumes the head entry.
REQ-011 out_inst  output  32  head instruction word; bits [31:7] drive the immediate extender inst input.
REQ-012 out_pc  output  32  head PC.
REQ-013 type_imm  output  3  immediate-type select for the extender: 0 U, 1 I, 2 B, 3 J, 4 S, 5 CSR, 6 shamt, 7 none (extender yields 0).
REQ-014 out_illegal  output  1  head instruction has an unsupported opcode.
REQ-015 ret_cnt  output  CNT_W  count of completed output handshakes.

Function
REQ-016 Storage: 2-entry FIFO; each entry holds inst, pc, type_imm, illegal; decode is performed at enqueue and stored.
REQ-017 Decode on opcode inst[6:0]:
- 0110111, 0010111 -> 0.
- 1100111, 0000011 -> 1.
- 0010011 -> 6 if funct3 is 001 or 101, else 1.
- 1100011 -> 2; 1101111 -> 3; 0100011 -> 4.
- 1110011 -> 5 if funct3[2]=1, else 7.
- 0110011, 0001111 -> 7.
- Any other opcode -> type 7, illegal=1.
REQ-018 Enqueue occurs when in_valid & in_ready; dequeue occurs when out_valid & out_ready.
REQ-019 in_ready = (state==RUN) & (count<2) & ~flush, and depends only on registered state and flush, never on out_ready.
REQ-020 out_valid = (state==RUN) & (count>0); out_inst, out_pc, type_imm and out_illegal reflect the head entry and are all-zero when out_valid=0.
REQ-021 Latency: an instruction accepted in cycle N appears on out_valid in cycle N+1 at the earliest; there is no combinational in->out path.
REQ-022 Simultaneous enqueue and dequeue at count=1: count stays 1 and the new entry becomes head next cycle.
REQ-023 Head outputs are stable while out_valid=1 and out_ready=0.
REQ-024 FIFO order is strictly preserved; the 1-bit read and write pointers wrap modulo 2.
REQ-025 FSM has two states, RUN and HALT:
- RUN -> HALT on dequeue of an entry with illegal=1.
- HALT -> RUN only on flush.
REQ-026 In HALT: in_ready=0, out_valid=0, and remaining entries are retained but not presented.
REQ-027 Flush, in the same clock edge: count=0, pointers=0, state=RUN; a simultaneous enqueue or dequeue is ignored; ret_cnt is unaffected.
REQ-028 ret_cnt increments by 1 per dequeue, including an illegal dequeue, and wraps from 2^CNT_W-1 to 0.

Reset
REQ-029 While rst_n=0:
- count=0, pointers=0, state=RUN, ret_cnt=0.
- in_ready=0 (held low during reset), out_valid=0, out_inst=0, out_pc=0, type_imm=0, out_illegal=0.
REQ-030 Reset assertion mid-transfer drops all buffered entries immediately without waiting for a clock edge.
REQ-031 After rst_n deasserts, in_ready=1 from the first clock edge.

Verification
REQ-032 Enqueue 0x000012B7 (lui), 0x00500093 (addi), 0x00309093 (slli) with out_ready=1 -> type_imm 0, 1, 6 on consecutive cycles; ret_cnt=3.
REQ-033 Enqueue 0x00000063 (beq) then 0x3401D073 (csrrwi) with out_ready=0 -> in_ready=0 after 2 accepts, head holds type_imm=2; raise out_ready -> type_imm 2 then 5.
REQ-034 Enqueue 0x00000000 -> out_illegal=1, type_imm=7; after its dequeue, in_ready=0 and out_valid=0 until flush, then in_ready=1.
REQ-035 FIFO full with flush=1 and in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, and the offered instruction is not stored.
REQ-036 Preload ret_cnt to 0xFFFF (CNT_W=16), then perform 1 dequeue -> ret_cnt=0x0000; assert rst_n=0 asynchronously while FIFO holds 2 entries -> out_valid=0 before the next edge.
